// File: rtl/altsyncram_pkg.sv
// Shared constants and the byte-lane mask helper for the true-dual-port RAM model.
package altsyncram_pkg;

  localparam int unsigned RDW_OLD_DATA  = 0;
  localparam int unsigned RDW_NEW_DATA  = 1;
  localparam int unsigned OUTREG_NONE   = 0;
  localparam int unsigned OUTREG_CLOCK0 = 1;

  localparam int unsigned MASK_MAX = 1024;
  typedef logic [MASK_MAX-1:0] mask_t;

  // Expands one enable bit per lane into byte_size consecutive mask bits.
  function automatic mask_t byte_mask(input mask_t byteena, input int unsigned byte_size);
    mask_t m;
    m = '0;
    if (byte_size != 0) begin
      for (int unsigned k = 0; k < MASK_MAX; k++) begin
        m[k] = byteena[k / byte_size];
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/altsyncram_tdp_if.sv
// One RAM port: request/write bus driven by the client, read data and valid returned.
interface altsyncram_tdp_if #(
  parameter int unsigned width     = 32,
  parameter int unsigned num_bytes = 4,
  parameter int unsigned widthad   = 11
);
  logic                 rden;
  logic                 wren;
  logic [widthad-1:0]   address;
  logic [num_bytes-1:0] byteena;
  logic [width-1:0]     data;
  logic [width-1:0]     q;
  logic                 rdvalid;

  modport master (
    output rden, wren, address, byteena, data,
    input  q, rdvalid
  );

  modport slave (
    input  rden, wren, address, byteena, data,
    output q, rdvalid
  );
endinterface

// File: rtl/altsyncram_port.sv
// Per-port read pipeline: read-during-write select, capture stage, optional output register.
module altsyncram_port #(
  parameter int unsigned width       = 32,
  parameter int unsigned outdata_reg = 0,
  parameter int unsigned rdw_mode    = 0
) (
  input  logic             clock0,
  input  logic             aclr0_n,
  input  logic             clocken0,
  input  logic             rden,
  input  logic             wren,
  input  logic [width-1:0] word_old,
  input  logic [width-1:0] word_new,
  output logic [width-1:0] q,
  output logic             rdvalid
);
  import altsyncram_pkg::*;

  logic [width-1:0] rd_word;
  logic [width-1:0] s1_data;
  logic             s1_valid;
  logic             sel_new;

  always_comb begin
    sel_new = wren && (rdw_mode == RDW_NEW_DATA);
    rd_word = sel_new ? word_new : word_old;
  end

  // Data is captured at the request edge so mixed-port writes never leak into it.
  always_ff @(posedge clock0 or negedge aclr0_n) begin
    if (!aclr0_n) begin
      s1_data  <= '0;
      s1_valid <= 1'b0;
    end else if (clocken0) begin
      s1_valid <= rden;
      if (rden) s1_data <= rd_word;
    end
  end

  if (outdata_reg == OUTREG_CLOCK0) begin : g_oreg
    always_ff @(posedge clock0 or negedge aclr0_n) begin
      if (!aclr0_n) begin
        q       <= '0;
        rdvalid <= 1'b0;
      end else if (clocken0) begin
        rdvalid <= s1_valid;
        if (s1_valid) q <= s1_data;
      end
    end
  end else begin : g_noreg
    assign q       = s1_data;
    assign rdvalid = s1_valid;
  end

endmodule

// File: rtl/altsyncram_tdp.sv
// True-dual-port synchronous RAM: shared array, write merge with port-A priority, collision flag.
module altsyncram_tdp #(
  parameter int unsigned width       = 32,
  parameter int unsigned byte_size   = 8,
  parameter int unsigned num_bytes   = 4,
  parameter int unsigned widthad     = 11,
  parameter int unsigned numwords    = 2048,
  parameter int unsigned outdata_reg = 0,
  parameter int unsigned rdw_mode    = 0,
  parameter string       init_file   = ""
) (
  input  logic              clock0,
  input  logic              aclr0_n,
  input  logic              clocken0,
  altsyncram_tdp_if.slave   port_a,
  altsyncram_tdp_if.slave   port_b,
  output logic              collision
);
  import altsyncram_pkg::*;

  if (width != byte_size * num_bytes) begin : g_bad_width
    $error("altsyncram_tdp: width %0d differs from byte_size*num_bytes %0d", width, byte_size * num_bytes);
  end
  if (numwords > (2 ** widthad)) begin : g_bad_depth
    $error("altsyncram_tdp: numwords %0d exceeds address range", numwords);
  end

  logic [width-1:0] mem [0:numwords-1];

  logic             a_in, b_in, a_wr, b_wr, same_addr;
  logic [width-1:0] mask_a, mask_b;
  logic [width-1:0] old_a, old_b, new_a, new_b;

  always_comb begin
    a_in      = 32'(port_a.address) < numwords;
    b_in      = 32'(port_b.address) < numwords;
    a_wr      = port_a.wren && a_in;
    b_wr      = port_b.wren && b_in;
    same_addr = port_a.address == port_b.address;
    mask_a    = width'(byte_mask(mask_t'(port_a.byteena), byte_size));
    mask_b    = width'(byte_mask(mask_t'(port_b.byteena), byte_size));
    old_a     = a_in ? mem[port_a.address] : 'x;
    old_b     = b_in ? mem[port_b.address] : 'x;

    // B lanes applied first, A last, so A owns any lane both ports enable.
    new_a = old_a;
    if (b_wr && same_addr) new_a = (new_a & ~mask_b) | (port_b.data & mask_b);
    if (a_wr)              new_a = (new_a & ~mask_a) | (port_a.data & mask_a);
    new_b = old_b;
    if (b_wr)              new_b = (new_b & ~mask_b) | (port_b.data & mask_b);
    if (a_wr && same_addr) new_b = (new_b & ~mask_a) | (port_a.data & mask_a);
  end

  always_ff @(posedge clock0) begin
    if (clocken0) begin
      if (b_wr) mem[port_b.address] <= new_b;
      if (a_wr) mem[port_a.address] <= new_a;
    end
  end

  always_ff @(posedge clock0 or negedge aclr0_n) begin
    if (!aclr0_n) begin
      collision <= 1'b0;
    end else if (clocken0) begin
      collision <= a_wr && b_wr && same_addr;
    end
  end

  altsyncram_port #(
    .width       (width),
    .outdata_reg (outdata_reg),
    .rdw_mode    (rdw_mode)
  ) u_port_a (
    .clock0   (clock0),
    .aclr0_n  (aclr0_n),
    .clocken0 (clocken0),
    .rden     (port_a.rden),
    .wren     (a_wr),
    .word_old (old_a),
    .word_new (new_a),
    .q        (port_a.q),
    .rdvalid  (port_a.rdvalid)
  );

  altsyncram_port #(
    .width       (width),
    .outdata_reg (outdata_reg),
    .rdw_mode    (rdw_mode)
  ) u_port_b (
    .clock0   (clock0),
    .aclr0_n  (aclr0_n),
    .clocken0 (clocken0),
    .rden     (port_b.rden),
    .wren     (b_wr),
    .word_old (old_b),
    .word_new (new_b),
    .q        (port_b.q),
    .rdvalid  (port_b.rdvalid)
  );

endmodule

// File: tb/tb_altsyncram_tdp.sv
// Drives two RAM configurations (1-cycle/OLD_DATA and 2-cycle/NEW_DATA) with shared stimulus.
module tb_altsyncram_tdp;

  localparam int NW = 2000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ce = 1'b1;
  logic a_rden = 0, a_wren = 0, b_rden = 0, b_wren = 0;
  logic [10:0] a_addr = '0, b_addr = '0;
  logic [3:0]  a_be = '0, b_be = '0;
  logic [31:0] a_data = '0, b_data = '0;
  logic coll0, coll1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  altsyncram_tdp_if #(.width(32), .num_bytes(4), .widthad(11)) ia0 ();
  altsyncram_tdp_if #(.width(32), .num_bytes(4), .widthad(11)) ib0 ();
  altsyncram_tdp_if #(.width(32), .num_bytes(4), .widthad(11)) ia1 ();
  altsyncram_tdp_if #(.width(32), .num_bytes(4), .widthad(11)) ib1 ();

  assign ia0.rden = a_rden;  assign ia0.wren = a_wren;  assign ia0.address = a_addr;
  assign ia0.byteena = a_be; assign ia0.data = a_data;
  assign ia1.rden = a_rden;  assign ia1.wren = a_wren;  assign ia1.address = a_addr;
  assign ia1.byteena = a_be; assign ia1.data = a_data;
  assign ib0.rden = b_rden;  assign ib0.wren = b_wren;  assign ib0.address = b_addr;
  assign ib0.byteena = b_be; assign ib0.data = b_data;
  assign ib1.rden = b_rden;  assign ib1.wren = b_wren;  assign ib1.address = b_addr;
  assign ib1.byteena = b_be; assign ib1.data = b_data;

  altsyncram_tdp #(.numwords(NW), .outdata_reg(0), .rdw_mode(0)) dut0 (
    .clock0(clk), .aclr0_n(rst_n), .clocken0(ce),
    .port_a(ia0), .port_b(ib0), .collision(coll0));

  altsyncram_tdp #(.numwords(NW), .outdata_reg(1), .rdw_mode(1)) dut1 (
    .clock0(clk), .aclr0_n(rst_n), .clocken0(ce),
    .port_a(ia1), .port_b(ib1), .collision(coll1));

  // Reference: word values plus a known-bit mask (memory starts undefined).
  logic [31:0] mm [0:2047];
  logic [31:0] mk [0:2047];
  logic [31:0] eq [2][2];
  logic [31:0] ek [2][2];
  logic        ev [2][2];
  logic [31:0] pd [2];
  logic [31:0] pk [2];
  logic        pv [2];
  logic        ecoll;

  logic [10:0] atab [11] = '{11'd0, 11'd1, 11'd2, 11'd3, 11'd4, 11'd5, 11'd6, 11'd7,
                             11'd1999, 11'd2000, 11'd2047};

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++)
      for (int p = 0; p < 2; p++) begin
        eq[c][p] = '0; ek[c][p] = '1; ev[c][p] = 1'b0;
      end
    pv[0] = 1'b0; pv[1] = 1'b0;
    ecoll = 1'b0;
  endtask

  task automatic model_edge();
    logic [10:0] ad [2];
    logic        rd [2], wr [2], inr [2];
    logic [3:0]  be [2];
    logic [31:0] dt [2], ow [2], ok [2], nw [2], nk [2], r, rk;
    if (!rst_n || !ce) return;
    ad[0] = a_addr; rd[0] = a_rden; wr[0] = a_wren; be[0] = a_be; dt[0] = a_data;
    ad[1] = b_addr; rd[1] = b_rden; wr[1] = b_wren; be[1] = b_be; dt[1] = b_data;
    for (int p = 0; p < 2; p++) begin
      inr[p] = 32'(ad[p]) < NW;
      ow[p] = inr[p] ? mm[ad[p]] : '0;
      ok[p] = inr[p] ? mk[ad[p]] : '0;
    end
    for (int p = 0; p < 2; p++) begin
      nw[p] = ow[p]; nk[p] = ok[p];
      for (int s = 1; s >= 0; s--)
        if (wr[s] && inr[s] && ad[s] == ad[p])
          for (int l = 0; l < 4; l++)
            if (be[s][l]) begin
              nw[p][8*l +: 8] = dt[s][8*l +: 8];
              nk[p][8*l +: 8] = 8'hFF;
            end
    end
    for (int p = 0; p < 2; p++) begin
      ev[0][p] = rd[p];
      if (rd[p]) begin eq[0][p] = ow[p]; ek[0][p] = ok[p]; end
      r  = (wr[p] && inr[p]) ? nw[p] : ow[p];
      rk = (wr[p] && inr[p]) ? nk[p] : ok[p];
      ev[1][p] = pv[p];
      if (pv[p]) begin eq[1][p] = pd[p]; ek[1][p] = pk[p]; end
      pv[p] = rd[p];
      if (rd[p]) begin pd[p] = r; pk[p] = rk; end
    end
    ecoll = wr[0] && wr[1] && inr[0] && inr[1] && ad[0] == ad[1];
    for (int p = 0; p < 2; p++)
      if (wr[p] && inr[p]) begin mm[ad[p]] = nw[p]; mk[ad[p]] = nk[p]; end
  endtask

  task automatic check_port(int c, int p, logic [31:0] q, logic rv);
    chk($sformatf("rdvalid c%0d p%0d", c, p), 32'(rv), 32'(ev[c][p]));
    if (ek[c][p] != '0)
      chk($sformatf("q c%0d p%0d", c, p), q & ek[c][p], eq[c][p] & ek[c][p]);
  endtask

  task automatic check_all();
    check_port(0, 0, ia0.q, ia0.rdvalid);
    check_port(0, 1, ib0.q, ib0.rdvalid);
    check_port(1, 0, ia1.q, ia1.rdvalid);
    check_port(1, 1, ib1.q, ib1.rdvalid);
    chk("collision c0", 32'(coll0), 32'(ecoll));
    chk("collision c1", 32'(coll1), 32'(ecoll));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic set_a(logic rd, logic wr, logic [10:0] ad, logic [3:0] be, logic [31:0] d);
    a_rden = rd; a_wren = wr; a_addr = ad; a_be = be; a_data = d;
  endtask

  task automatic set_b(logic rd, logic wr, logic [10:0] ad, logic [3:0] be, logic [31:0] d);
    b_rden = rd; b_wren = wr; b_addr = ad; b_be = be; b_data = d;
  endtask

  task automatic idle();
    a_rden = 0; a_wren = 0; b_rden = 0; b_wren = 0;
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) begin mm[i] = '0; mk[i] = '0; end
    model_reset();
    #23;
    check_all();
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Cross-port write then read, both latencies
    set_a(0, 1, 11'h010, 4'hF, 32'hDEADBEEF); step();
    idle(); set_b(1, 0, 11'h010, 4'h0, 32'h0); step();
    chk("tp1 q_b c0", ib0.q, 32'hDEADBEEF);
    chk("tp1 rdvalid_b c1 early", 32'(ib1.rdvalid), 32'd0);
    idle(); step();
    chk("tp1 q_b c1", ib1.q, 32'hDEADBEEF);
    chk("tp1 rdvalid_b c1", 32'(ib1.rdvalid), 32'd1);

    // Partial byte-enable write
    set_a(0, 1, 11'h020, 4'hF, 32'h11223344); step();
    set_a(0, 1, 11'h020, 4'b0101, 32'hAABBCCDD); step();
    idle(); set_b(1, 0, 11'h020, 4'h0, 32'h0); step();
    chk("partial q_b c0", ib0.q, 32'h11BB33DD);
    idle(); step();

    // Same-port and mixed-port read-during-write
    set_a(0, 1, 11'h030, 4'hF, 32'h0); step();
    set_a(1, 1, 11'h030, 4'hF, 32'h5A5A5A5A); set_b(1, 0, 11'h030, 4'h0, 32'h0); step();
    chk("rdw old q_a c0", ia0.q, 32'h0);
    chk("mixed q_b c0", ib0.q, 32'h0);
    idle(); step();
    chk("rdw new q_a c1", ia1.q, 32'h5A5A5A5A);
    chk("mixed q_b c1", ib1.q, 32'h0);

    // Write-write collision
    set_a(0, 1, 11'h040, 4'b0011, 32'hFFFFFFFF); set_b(0, 1, 11'h040, 4'hF, 32'h0); step();
    chk("collision pulse", 32'(coll0), 32'd1);
    idle(); step();
    chk("collision clear", 32'(coll0), 32'd0);
    set_a(1, 0, 11'h040, 4'h0, 32'h0); step();
    chk("collision word", ia0.q, 32'h0000FFFF);
    idle(); step();

    // Clock-enable stall during back-to-back reads
    for (int i = 0; i < 3; i++) begin
      set_a(0, 1, 11'(i), 4'hF, 32'h1000 + 32'(i)); step();
    end
    idle(); step();
    set_b(1, 0, 11'h000, 4'h0, 32'h0); step();
    set_b(1, 0, 11'h001, 4'h0, 32'h0); ce = 1'b0; step();
    chk("stall q_b c0", ib0.q, 32'h1000);
    chk("stall rdvalid_b c0", 32'(ib0.rdvalid), 32'd1);
    ce = 1'b1; step();
    chk("resume q_b c0", ib0.q, 32'h1001);
    set_b(1, 0, 11'h002, 4'h0, 32'h0); step();
    idle(); step(); step();

    // Reset with a read in flight
    set_b(1, 0, 11'h010, 4'h0, 32'h0); step();
    idle();
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all();
    step();
    rst_n = 1'b1;
    step(); step();
    chk("after reset rdvalid_b c1", 32'(ib1.rdvalid), 32'd0);
    set_b(1, 0, 11'h010, 4'h0, 32'h0); step();
    idle(); step();
    chk("mem kept q_b c1", ib1.q, 32'hDEADBEEF);

    // Randomized traffic against the reference
    for (int n = 0; n < 400; n++) begin
      ce = ($urandom_range(0, 9) != 0);
      set_a(1'($urandom), 1'($urandom), atab[$urandom_range(0, 10)], 4'($urandom), $urandom);
      set_b(1'($urandom), 1'($urandom), atab[$urandom_range(0, 10)], 4'($urandom), $urandom);
      step();
    end
    ce = 1'b1; idle(); step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
